// File: rtl/tlb_array.sv
// Fully associative TLB storage: two combinational search ports, one read
// port, one write port and an INVTLB-style bulk invalidate.
module tlb_array #(
    parameter int unsigned TLBNUM = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    // search port 0
    input  logic [18:0]                 s0_vppn,
    input  logic                        s0_va_bit12,
    input  logic [9:0]                  s0_asid,
    output logic                        s0_found,
    output logic [$clog2(TLBNUM)-1:0]   s0_index,
    output logic [19:0]                 s0_ppn,
    output logic [5:0]                  s0_ps,
    output logic [1:0]                  s0_plv,
    output logic [1:0]                  s0_mat,
    output logic                        s0_d,
    output logic                        s0_v,
    // search port 1 (also supplies the invalidate match keys)
    input  logic [18:0]                 s1_vppn,
    input  logic                        s1_va_bit12,
    input  logic [9:0]                  s1_asid,
    output logic                        s1_found,
    output logic [$clog2(TLBNUM)-1:0]   s1_index,
    output logic [19:0]                 s1_ppn,
    output logic [5:0]                  s1_ps,
    output logic [1:0]                  s1_plv,
    output logic [1:0]                  s1_mat,
    output logic                        s1_d,
    output logic                        s1_v,
    // invalidate
    input  logic                        invtlb_valid,
    input  logic [4:0]                  invtlb_op,
    // write port
    input  logic                        we,
    input  logic [$clog2(TLBNUM)-1:0]   w_index,
    input  logic                        w_e,
    input  logic [18:0]                 w_vppn,
    input  logic [5:0]                  w_ps,
    input  logic [9:0]                  w_asid,
    input  logic                        w_g,
    input  logic [19:0]                 w_ppn0,
    input  logic [1:0]                  w_plv0,
    input  logic [1:0]                  w_mat0,
    input  logic                        w_d0,
    input  logic                        w_v0,
    input  logic [19:0]                 w_ppn1,
    input  logic [1:0]                  w_plv1,
    input  logic [1:0]                  w_mat1,
    input  logic                        w_d1,
    input  logic                        w_v1,
    // read port
    input  logic [$clog2(TLBNUM)-1:0]   r_index,
    output logic                        r_e,
    output logic [18:0]                 r_vppn,
    output logic [5:0]                  r_ps,
    output logic [9:0]                  r_asid,
    output logic                        r_g,
    output logic [19:0]                 r_ppn0,
    output logic [1:0]                  r_plv0,
    output logic [1:0]                  r_mat0,
    output logic                        r_d0,
    output logic                        r_v0,
    output logic [19:0]                 r_ppn1,
    output logic [1:0]                  r_plv1,
    output logic [1:0]                  r_mat1,
    output logic                        r_d1,
    output logic                        r_v1
);

    localparam int unsigned IDXW = $clog2(TLBNUM);

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } page_t;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        page_t       p0;
        page_t       p1;
    } entry_t;

    entry_t             tlb [TLBNUM];
    entry_t             w_entry;
    logic [TLBNUM-1:0]  m0, m1, inv_sel;
    logic [IDXW-1:0]    idx0, idx1;
    page_t              pg0, pg1;

    // PS=12 compares the full VPPN; any larger page compares only VPPN[18:9]
    function automatic logic va_match(entry_t ent, logic [18:0] vppn);
        if (ent.ps == 6'd12) return ent.vppn == vppn;
        return ent.vppn[18:9] == vppn[18:9];
    endfunction

    // lowest set bit wins
    function automatic logic [IDXW-1:0] first_hit(logic [TLBNUM-1:0] m);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
            if (m[i]) idx = IDXW'(i);
        end
        return idx;
    endfunction

    // odd page for PS=12 is VA bit 12, otherwise VPPN bit 8
    function automatic page_t pick_page(entry_t ent, logic bit12, logic [18:0] vppn);
        logic odd;
        odd = (ent.ps == 6'd12) ? bit12 : vppn[8];
        return odd ? ent.p1 : ent.p0;
    endfunction

    assign w_entry = '{e: w_e, vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                       p0: '{ppn: w_ppn0, plv: w_plv0, mat: w_mat0, d: w_d0, v: w_v0},
                       p1: '{ppn: w_ppn1, plv: w_plv1, mat: w_mat1, d: w_d1, v: w_v1}};

    // per-entry hit vectors for both search ports
    always_comb begin
        m0 = '0;
        m1 = '0;
        for (int i = 0; i < int'(TLBNUM); i++) begin
            m0[i] = tlb[i].e && (tlb[i].g || tlb[i].asid == s0_asid) && va_match(tlb[i], s0_vppn);
            m1[i] = tlb[i].e && (tlb[i].g || tlb[i].asid == s1_asid) && va_match(tlb[i], s1_vppn);
        end
    end

    // invalidate selection, keyed by the port-1 search inputs
    always_comb begin
        logic asid_hit;
        logic va_hit;
        inv_sel  = '0;
        asid_hit = 1'b0;
        va_hit   = 1'b0;
        for (int i = 0; i < int'(TLBNUM); i++) begin
            asid_hit = tlb[i].asid == s1_asid;
            va_hit   = va_match(tlb[i], s1_vppn);
            case (invtlb_op)
                5'd0, 5'd1: inv_sel[i] = 1'b1;
                5'd2:       inv_sel[i] = tlb[i].g;
                5'd3:       inv_sel[i] = !tlb[i].g;
                5'd4:       inv_sel[i] = !tlb[i].g && asid_hit;
                5'd5:       inv_sel[i] = !tlb[i].g && asid_hit && va_hit;
                5'd6:       inv_sel[i] = (tlb[i].g || asid_hit) && va_hit;
                default:    inv_sel[i] = 1'b0;
            endcase
        end
    end

    // entry storage: write has priority over invalidate on the same entry
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(TLBNUM); i++) tlb[i] <= '0;
        end else begin
            for (int i = 0; i < int'(TLBNUM); i++) begin
                if (we && w_index == IDXW'(i)) tlb[i] <= w_entry;
                else if (invtlb_valid && inv_sel[i]) tlb[i].e <= 1'b0;
            end
        end
    end

    assign idx0 = first_hit(m0);
    assign idx1 = first_hit(m1);
    assign pg0  = (|m0) ? pick_page(tlb[idx0], s0_va_bit12, s0_vppn) : '0;
    assign pg1  = (|m1) ? pick_page(tlb[idx1], s1_va_bit12, s1_vppn) : '0;

    assign s0_found = |m0;
    assign s0_index = s0_found ? idx0 : '0;
    assign s0_ps    = s0_found ? tlb[idx0].ps : '0;
    assign s0_ppn   = pg0.ppn;
    assign s0_plv   = pg0.plv;
    assign s0_mat   = pg0.mat;
    assign s0_d     = pg0.d;
    assign s0_v     = pg0.v;

    assign s1_found = |m1;
    assign s1_index = s1_found ? idx1 : '0;
    assign s1_ps    = s1_found ? tlb[idx1].ps : '0;
    assign s1_ppn   = pg1.ppn;
    assign s1_plv   = pg1.plv;
    assign s1_mat   = pg1.mat;
    assign s1_d     = pg1.d;
    assign s1_v     = pg1.v;

    assign r_e      = tlb[r_index].e;
    assign r_vppn   = tlb[r_index].vppn;
    assign r_ps     = tlb[r_index].ps;
    assign r_asid   = tlb[r_index].asid;
    assign r_g      = tlb[r_index].g;
    assign r_ppn0   = tlb[r_index].p0.ppn;
    assign r_plv0   = tlb[r_index].p0.plv;
    assign r_mat0   = tlb[r_index].p0.mat;
    assign r_d0     = tlb[r_index].p0.d;
    assign r_v0     = tlb[r_index].p0.v;
    assign r_ppn1   = tlb[r_index].p1.ppn;
    assign r_plv1   = tlb[r_index].p1.plv;
    assign r_mat1   = tlb[r_index].p1.mat;
    assign r_d1     = tlb[r_index].p1.d;
    assign r_v1     = tlb[r_index].p1.v;

endmodule

// File: tb/tb_tlb_array.sv
// Directed bench for tlb_array: search, read, write, invalidate and reset.
module tb_tlb_array;

    logic        clk = 1'b0;
    logic        resetn;
    logic [18:0] s0_vppn, s1_vppn;
    logic        s0_va_bit12, s1_va_bit12;
    logic [9:0]  s0_asid, s1_asid;
    logic        s0_found, s1_found;
    logic [3:0]  s0_index, s1_index;
    logic [19:0] s0_ppn, s1_ppn;
    logic [5:0]  s0_ps, s1_ps;
    logic [1:0]  s0_plv, s1_plv, s0_mat, s1_mat;
    logic        s0_d, s1_d, s0_v, s1_v;
    logic        invtlb_valid;
    logic [4:0]  invtlb_op;
    logic        we;
    logic [3:0]  w_index, r_index;
    logic        w_e, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [18:0] w_vppn;
    logic [5:0]  w_ps;
    logic [9:0]  w_asid;
    logic [19:0] w_ppn0, w_ppn1;
    logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1;
    logic        r_e, r_g, r_d0, r_v0, r_d1, r_v1;
    logic [18:0] r_vppn;
    logic [5:0]  r_ps;
    logic [9:0]  r_asid;
    logic [19:0] r_ppn0, r_ppn1;
    logic [1:0]  r_plv0, r_mat0, r_plv1, r_mat1;

    int errors = 0;
    int checks = 0;

    tlb_array #(.TLBNUM(16)) dut (
        .clk(clk), .resetn(resetn),
        .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps),
        .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps),
        .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
        .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
        .w_asid(w_asid), .w_g(w_g),
        .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
        .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid),
        .r_g(r_g),
        .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
        .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // fixed page attributes: page0 plv=1 mat=1 d=0, page1 plv=2 mat=3 d=1, both valid
    task automatic set_w(input logic [3:0] idx, input logic e, input logic [18:0] vppn,
                         input logic [5:0] ps, input logic [9:0] asid, input logic g,
                         input logic [19:0] ppn0, input logic [19:0] ppn1);
        we = 1'b1; w_index = idx; w_e = e; w_vppn = vppn; w_ps = ps; w_asid = asid; w_g = g;
        w_ppn0 = ppn0; w_plv0 = 2'd1; w_mat0 = 2'd1; w_d0 = 1'b0; w_v0 = 1'b1;
        w_ppn1 = ppn1; w_plv1 = 2'd2; w_mat1 = 2'd3; w_d1 = 1'b1; w_v1 = 1'b1;
    endtask

    task automatic wr(input logic [3:0] idx, input logic e, input logic [18:0] vppn,
                      input logic [5:0] ps, input logic [9:0] asid, input logic g,
                      input logic [19:0] ppn0, input logic [19:0] ppn1);
        set_w(idx, e, vppn, ps, asid, g, ppn0, ppn1);
        tick();
        we = 1'b0;
    endtask

    task automatic inv(input logic [4:0] op);
        invtlb_valid = 1'b1;
        invtlb_op    = op;
        tick();
        invtlb_valid = 1'b0;
    endtask

    task automatic rd_e(input string tag, input logic [3:0] idx, input logic exp);
        r_index = idx;
        #1;
        chk(tag, 32'(r_e), 32'(exp));
    endtask

    initial begin
        resetn = 1'b0;
        s0_vppn = '0; s0_va_bit12 = 1'b0; s0_asid = '0;
        s1_vppn = '0; s1_va_bit12 = 1'b0; s1_asid = '0;
        invtlb_valid = 1'b0; invtlb_op = '0; r_index = '0;
        set_w(4'd0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
        we = 1'b0;
        #2;
        chk("rst_s0_found", 32'(s0_found), 32'd0);
        chk("rst_r_e", 32'(r_e), 32'd0);
        chk("rst_r_ppn1", 32'(r_ppn1), 32'd0);
        #10 resetn = 1'b1;
        tick();

        // basic 4K hit, odd and even page, ASID miss
        wr(4'd3, 1'b1, 19'h12345, 6'd12, 10'h005, 1'b0, 20'hAAAAA, 20'hBBBBB);
        s0_vppn = 19'h12345; s0_va_bit12 = 1'b1; s0_asid = 10'h005;
        #1;
        chk("b_found", 32'(s0_found), 32'd1);
        chk("b_index", 32'(s0_index), 32'd3);
        chk("b_ppn_odd", 32'(s0_ppn), 32'hBBBBB);
        chk("b_ps", 32'(s0_ps), 32'd12);
        chk("b_plv_odd", 32'(s0_plv), 32'd2);
        chk("b_mat_odd", 32'(s0_mat), 32'd3);
        chk("b_d_odd", 32'(s0_d), 32'd1);
        s0_va_bit12 = 1'b0;
        #1;
        chk("b_ppn_even", 32'(s0_ppn), 32'hAAAAA);
        chk("b_d_even", 32'(s0_d), 32'd0);
        s0_asid = 10'h006;
        #1;
        chk("b_miss_found", 32'(s0_found), 32'd0);
        chk("b_miss_index", 32'(s0_index), 32'd0);
        chk("b_miss_ppn", 32'(s0_ppn), 32'd0);
        chk("b_miss_ps", 32'(s0_ps), 32'd0);
        chk("b_miss_v", 32'(s0_v), 32'd0);

        // 2M global page: only VPPN[18:9] compared, VPPN[8] picks the page
        wr(4'd7, 1'b1, 19'h40000, 6'd21, 10'h3FF, 1'b1, 20'h11111, 20'h22222);
        s1_vppn = 19'h401FF; s1_asid = 10'h123;
        s0_vppn = 19'h40200; s0_asid = 10'h123;
        #1;
        chk("h_s1_found", 32'(s1_found), 32'd1);
        chk("h_s1_index", 32'(s1_index), 32'd7);
        chk("h_s1_ppn_odd", 32'(s1_ppn), 32'h22222);
        chk("h_s1_ps", 32'(s1_ps), 32'd21);
        chk("h_s0_found", 32'(s0_found), 32'd0);
        s1_vppn = 19'h40000;
        #1;
        chk("h_s1_ppn_even", 32'(s1_ppn), 32'h11111);

        // duplicate keys: lowest index wins; write in same cycle is not yet visible
        wr(4'd9, 1'b1, 19'h0ABCD, 6'd12, 10'h02A, 1'b0, 20'h00900, 20'h00901);
        wr(4'd2, 1'b1, 19'h0ABCD, 6'd12, 10'h02A, 1'b0, 20'h00200, 20'h00201);
        s0_vppn = 19'h0ABCD; s0_va_bit12 = 1'b0; s0_asid = 10'h02A;
        s1_vppn = 19'h0ABCD; s1_va_bit12 = 1'b1; s1_asid = 10'h02A;
        #1;
        chk("d_s0_index", 32'(s0_index), 32'd2);
        chk("d_s0_ppn", 32'(s0_ppn), 32'h00200);
        chk("d_s1_index", 32'(s1_index), 32'd2);
        chk("d_s1_ppn", 32'(s1_ppn), 32'h00201);
        set_w(4'd2, 1'b0, 19'h0ABCD, 6'd12, 10'h02A, 1'b0, 20'h00200, 20'h00201);
        #1;
        chk("d_wcyc_index", 32'(s0_index), 32'd2);
        tick();
        we = 1'b0;
        #1;
        chk("d_next_index", 32'(s0_index), 32'd9);
        chk("d_next_ppn", 32'(s0_ppn), 32'h00900);
        r_index = 4'd2;
        #1;
        chk("d_r2_e", 32'(r_e), 32'd0);
        chk("d_r2_vppn", 32'(r_vppn), 32'h0ABCD);

        // invalidate opcodes
        wr(4'd0, 1'b1, 19'h00010, 6'd12, 10'h001, 1'b1, 20'h00010, 20'h00011);
        wr(4'd1, 1'b1, 19'h00020, 6'd12, 10'h005, 1'b0, 20'h00020, 20'h00021);
        s1_asid = 10'h005;
        inv(5'd4);
        rd_e("i4_r1_e", 4'd1, 1'b0);
        chk("i4_r1_asid", 32'(r_asid), 32'h005);
        chk("i4_r1_ppn0", 32'(r_ppn0), 32'h00020);
        rd_e("i4_r0_e", 4'd0, 1'b1);
        rd_e("i4_r3_e", 4'd3, 1'b0);
        rd_e("i4_r9_e", 4'd9, 1'b1);
        inv(5'd2);
        rd_e("i2_r0_e", 4'd0, 1'b0);
        rd_e("i2_r7_e", 4'd7, 1'b0);
        rd_e("i2_r9_e", 4'd9, 1'b1);
        s1_asid = 10'h02A;
        inv(5'd7);
        rd_e("i7_r9_e", 4'd9, 1'b1);
        s1_vppn = 19'h0ABCE;
        inv(5'd5);
        rd_e("i5_miss_r9_e", 4'd9, 1'b1);
        s1_vppn = 19'h0ABCD;
        inv(5'd5);
        rd_e("i5_hit_r9_e", 4'd9, 1'b0);

        // write and flush-all in the same cycle: the written entry survives
        wr(4'd5, 1'b1, 19'h00050, 6'd12, 10'h001, 1'b1, 20'h00050, 20'h00051);
        wr(4'd6, 1'b1, 19'h00060, 6'd12, 10'h001, 1'b0, 20'h00060, 20'h00061);
        set_w(4'd4, 1'b1, 19'h7FFFF, 6'd12, 10'h3FF, 1'b0, 20'hFFFFF, 20'h12321);
        inv(5'd0);
        we = 1'b0;
        rd_e("c_r4_e", 4'd4, 1'b1);
        chk("c_r4_ppn1", 32'(r_ppn1), 32'h12321);
        rd_e("c_r5_e", 4'd5, 1'b0);
        rd_e("c_r6_e", 4'd6, 1'b0);

        // asynchronous reset mid-cycle clears everything without a clock edge
        s0_vppn = 19'h7FFFF; s0_va_bit12 = 1'b0; s0_asid = 10'h3FF;
        s1_vppn = 19'h7FFFF; s1_va_bit12 = 1'b1; s1_asid = 10'h3FF;
        r_index = 4'd4;
        #1;
        chk("r_pre_s0_found", 32'(s0_found), 32'd1);
        chk("r_pre_s0_ppn", 32'(s0_ppn), 32'hFFFFF);
        chk("r_pre_s1_index", 32'(s1_index), 32'd4);
        #1;
        resetn = 1'b0;
        #1;
        chk("r_s0_found", 32'(s0_found), 32'd0);
        chk("r_s1_found", 32'(s1_found), 32'd0);
        chk("r_s0_ppn", 32'(s0_ppn), 32'd0);
        chk("r_r_e", 32'(r_e), 32'd0);
        chk("r_r_vppn", 32'(r_vppn), 32'd0);
        chk("r_r_ppn1", 32'(r_ppn1), 32'd0);
        chk("r_r_asid", 32'(r_asid), 32'd0);
        // a write at an edge while reset is held is dropped
        set_w(4'd4, 1'b1, 19'h7FFFF, 6'd12, 10'h3FF, 1'b0, 20'hFFFFF, 20'h12321);
        tick();
        we = 1'b0;
        #1;
        chk("r_wdrop_e", 32'(r_e), 32'd0);
        chk("r_wdrop_found", 32'(s0_found), 32'd0);
        resetn = 1'b1;
        tick();
        chk("r_post_e", 32'(r_e), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlb_array.md
TLB_ARRAY -- requirements
Module: tlb_array

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, the number of entries (power of two); index width is log2(TLBNUM), 4 at the default.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports s0_vppn/s1_vppn  input  19  search virtual page-pair number.
REQ-005 SHALL have ports s0_va_bit12/s1_va_bit12  input  1  VA bit 12, used for odd/even page select.
REQ-006 SHALL have ports s0_asid/s1_asid  input  10  search ASID.
REQ-007 SHALL have ports s0_found/s1_found  output  1  hit flag.
REQ-008 SHALL have ports s0_index/s1_index  output  4  index of the hitting entry.
REQ-009 SHALL have per-port search result outputs s{0,1}_ppn 20, _ps 6, _plv 2, _mat 2, _d 1, _v 1.
REQ-010 SHALL have port invtlb_valid  input  1  invalidate request.
REQ-011 SHALL have port invtlb_op  input  5  invalidate opcode; its match keys are s1_asid, s1_vppn and s1_va_bit12.
REQ-012 SHALL have port we  input  1  write enable.
REQ-013 SHALL have port w_index  input  4  entry to write.
REQ-014 SHALL have write-data inputs w_e 1, w_vppn 19, w_ps 6, w_asid 10, w_g 1, w_ppn{0,1} 20, w_plv{0,1} 2, w_mat{0,1} 2, w_d{0,1} 1, w_v{0,1} 1.
REQ-015 SHALL have port r_index  input  4  entry to read.
REQ-016 SHALL have read-data outputs r_e, r_vppn, r_ps, r_asid, r_g, r_ppn{0,1}, r_plv{0,1}, r_mat{0,1}, r_d{0,1}, r_v{0,1}, with the same widths as the corresponding w_* inputs.

Function
REQ-017 SHALL hold TLBNUM entries in flops, each with the fields E, VPPN, PS, ASID, G and two page records {PPN, PLV, MAT, D, V}.
REQ-018 SHALL make the search and read outputs purely combinational from entry state and inputs, i.e. zero-cycle latency.
REQ-019 SHALL treat entry i as matching search port k when: E=1; and (G=1 or ASID==sk_asid); and the VPPN compare succeeds:
- PS=12: all 19 VPPN bits compared.
- PS=21: only VPPN[18:9] compared.
REQ-020 SHALL select the odd page when (PS=12 ? sk_va_bit12 : sk_vppn[8]) is 1, and the even page otherwise.
REQ-021 SHALL report the lowest matching index when several entries match.
REQ-022 SHALL drive found=0 and all search result fields to 0 when no entry matches.
REQ-023 SHALL make the two search ports fully independent: simultaneous identical or different keys both resolve correctly.
REQ-024 SHALL, when we=1, copy all w_* fields into entry w_index at the rising edge; a write with w_e=0 stores the entry as invalid.
REQ-025 SHALL leave the r_* outputs reflecting entry r_index's stored fields regardless of E.
REQ-026 SHALL make searches and reads in the write cycle return pre-write contents; new contents are visible from the next cycle.
REQ-027 SHALL, when invtlb_valid=1, clear E at the edge for every entry selected by invtlb_op:
- 0, 1: all entries.
- 2: G=1.
- 3: G=0.
- 4: G=0 and ASID match.
- 5: G=0 and ASID match and VA match.
- 6: (G=1 or ASID match) and VA match.
- Other opcodes: no state change.
- VA match uses the REQ-019 VPPN/PS rule.
REQ-028 SHALL let the write win when we and invtlb_valid coincide on the same entry; invalidation still applies to all other selected entries.
REQ-029 SHALL leave every field other than E unchanged on invalidate.

Reset
REQ-030 SHALL, while resetn=0, asynchronously clear all fields of all entries to 0.
REQ-031 SHALL drive found=0, all search outputs 0 and all r_* outputs 0 immediately upon reset assertion, including mid-operation.
REQ-032 SHALL drop a write or invalidate coincident with an edge while resetn=0.

Verification
REQ-033 Write idx3 {E=1, VPPN=0x12345, PS=12, ASID=0x05, G=0, PPN0=0xAAAAA, PPN1=0xBBBBB, V0=V1=1}, then s0 search VPPN=0x12345, bit12=1, ASID=0x05 -> found=1, index=3, ppn=0xBBBBB; same search with ASID=0x06 -> found=0, all results 0.
REQ-034 Write idx7 PS=21, G=1, VPPN=0x40000; s1 search VPPN=0x401FF, ASID=any -> index=7, odd page selected (vppn[8]=1); s0 search VPPN=0x40200 simultaneously -> found=0.
REQ-035 Fill idx2 and idx9 with identical matching keys -> found=1, index=2; then write idx2 w_e=0 -> search in that cycle returns index 2, next cycle returns index 9.
REQ-036 Entries G=1 at idx0 and G=0/ASID=5 at idx1; invtlb op=4 with s1_asid=5 -> next cycle r_index=1 shows r_e=0, idx0 r_e=1; op=2 -> idx0 r_e=0; op=7 -> no change.
REQ-037 Same cycle we to idx4 and invtlb op=0 -> idx4 E=1 afterwards, all other E=0.
REQ-038 Assert resetn=0 between clock edges with valid entries -> s0_found/s1_found fall to 0 without a clock edge, and all r_* read 0.
